hazard_unit: RTL and testbench

- Hazard and stall arbiter for the 5-stage pipeline.
- Consumes the stage-tagged control bits the controller pipelines (regwrite*, memtoreg*, branchD) and the datapath's register specifiers.
- Returns forward selects, stall enables and flushE to the datapath/controller.
- Adds a variable-latency data-memory wait FSM with timeout detection and saturating stall-cycle counters.

---
 rtl/hazard_unit.sv | 120 ++++++++++++
 tb/tb_hazard_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard and stall arbiter for the 5-stage pipeline: operand forwarding, load-use and
// branch stalls, a data-memory wait FSM with timeout, and saturating stall counters.
module hazard_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             branchD,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             memreqM,
    input  logic             memreadyM,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushE,
    output logic             flushW,
    output logic             memwait,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] hazard_stalls,
    output logic [CNT_W-1:0] mem_stalls
);

    typedef enum logic {MEM_IDLE, MEM_WAIT} memState_t;

    memState_t        state, nextState;
    logic [TO_W-1:0]  waitCnt, nextWaitCnt;
    logic             abortM;
    logic             timeoutHit;
    logic             lwStall, branchStall, memStall, hazStall;

    // Forwarding: M result wins over W, and register 0 is never forwarded.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (rsE != 5'd0 && rsE == writeregM && regwriteM)      forwardAE = 2'b10;
        else if (rsE != 5'd0 && rsE == writeregW && regwriteW) forwardAE = 2'b01;
        if (rtE != 5'd0 && rtE == writeregM && regwriteM)      forwardBE = 2'b10;
        else if (rtE != 5'd0 && rtE == writeregW && regwriteW) forwardBE = 2'b01;
        forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
        forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
    end

    // abortM masks the stall for the one cycle after a timeout so the stuck access can leave M.
    assign lwStall     = memtoregE && (rtE == rsD || rtE == rtD);
    assign branchStall = branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                                     (memtoregM && (writeregM == rsD || writeregM == rtD)));
    assign memStall    = memreqM && !memreadyM && !abortM;
    assign hazStall    = (lwStall || branchStall) && !memStall;

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        timeoutHit  = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (memStall) begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = '0;
                end
            end
            MEM_WAIT: begin
                if (memreadyM) begin
                    nextState = MEM_IDLE;
                end else if (waitCnt == TO_W'(TIMEOUT - 1)) begin
                    nextState  = MEM_IDLE;
                    timeoutHit = 1'b1;
                end else begin
                    nextWaitCnt = waitCnt + TO_W'(1);
                end
            end
            default: nextState = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= MEM_IDLE;
            waitCnt       <= '0;
            abortM        <= 1'b0;
            mem_timeout   <= 1'b0;
            hazard_stalls <= '0;
            mem_stalls    <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            abortM  <= timeoutHit;
            if (timeoutHit) mem_timeout <= 1'b1;
            if (hazStall && hazard_stalls != {CNT_W{1'b1}}) hazard_stalls <= hazard_stalls + CNT_W'(1);
            if (memStall && mem_stalls != {CNT_W{1'b1}})    mem_stalls    <= mem_stalls + CNT_W'(1);
        end
    end

    // Stall and flush requests are suppressed while the pipeline is held in reset.
    assign stallF  = reset && (memStall || lwStall || branchStall);
    assign stallD  = stallF;
    assign stallE  = reset && memStall;
    assign stallM  = stallE;
    assign flushW  = stallE;
    assign flushE  = reset && hazStall;
    assign memwait = (state == MEM_WAIT);

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expectations are queued as stimulus is applied and
// popped against the DUT outputs after the logic settles.
module tb_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    localparam int S_FAE = 0, S_FBE = 1, S_FAD = 2, S_FBD = 3, S_STF = 4, S_STD = 5,
                   S_STE = 6, S_STM = 7, S_FLE = 8, S_FLW = 9, S_MWT = 10, S_MTO = 11,
                   S_HZC = 12, S_MMC = 13;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memreqM, memreadyM;
    logic forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushE, flushW, memwait, mem_timeout;
    logic [1:0] forwardAE, forwardBE;
    logic [CNT_W-1:0] hazard_stalls, mem_stalls;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } expItem_t;

    expItem_t expQ[$];
    int checkCount = 0;
    int failCount  = 0;

    hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memreqM(memreqM), .memreadyM(memreadyM),
        .forwardAD(forwardAD), .forwardBD(forwardBD), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushW(flushW), .memwait(memwait), .mem_timeout(mem_timeout),
        .hazard_stalls(hazard_stalls), .mem_stalls(mem_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observed(input int sel);
        case (sel)
            S_FAE:   return 16'(forwardAE);
            S_FBE:   return 16'(forwardBE);
            S_FAD:   return 16'(forwardAD);
            S_FBD:   return 16'(forwardBD);
            S_STF:   return 16'(stallF);
            S_STD:   return 16'(stallD);
            S_STE:   return 16'(stallE);
            S_STM:   return 16'(stallM);
            S_FLE:   return 16'(flushE);
            S_FLW:   return 16'(flushW);
            S_MWT:   return 16'(memwait);
            S_MTO:   return 16'(mem_timeout);
            S_HZC:   return 16'(hazard_stalls);
            S_MMC:   return 16'(mem_stalls);
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input int sel, input logic [15:0] exp, input string tag);
        expQ.push_back('{tag: tag, sel: sel, exp: exp});
    endtask

    task automatic compareQueue();
        expItem_t item;
        #1;
        while (expQ.size() > 0) begin
            item = expQ.pop_front();
            checkOutput(item.tag, observed(item.sel), item.exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memreqM, memreadyM} = '0;
    endtask

    task automatic pushStalls(input logic f, input logic e, input logic fe, input string tag);
        pushExpect(S_STF, 16'(f), {tag, ".stallF"});
        pushExpect(S_STD, 16'(f), {tag, ".stallD"});
        pushExpect(S_STE, 16'(e), {tag, ".stallE"});
        pushExpect(S_STM, 16'(e), {tag, ".stallM"});
        pushExpect(S_FLW, 16'(e), {tag, ".flushW"});
        pushExpect(S_FLE, 16'(fe), {tag, ".flushE"});
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] fa, fb;
        clearInputs();

        // Reset holds stalls low even with a load-use pattern present
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        pushStalls(1'b0, 1'b0, 1'b0, "rst");
        compareQueue();
        applyStimulus();
        pushExpect(S_MWT, 16'd0, "rst.memwait");
        pushExpect(S_MTO, 16'd0, "rst.timeout");
        pushExpect(S_HZC, 16'd0, "rst.hazCnt");
        pushExpect(S_MMC, 16'd0, "rst.memCnt");
        compareQueue();
        reset = 1'b1;
        clearInputs();

        // Forward priority
        rsE = 5'd5; writeregM = 5'd5; regwriteM = 1'b1; writeregW = 5'd5; regwriteW = 1'b1;
        pushExpect(S_FAE, 16'd2, "fwd.M");
        compareQueue();
        regwriteM = 1'b0;
        pushExpect(S_FAE, 16'd1, "fwd.W");
        compareQueue();
        regwriteM = 1'b1; rsE = 5'd0; rtE = 5'd0;
        pushExpect(S_FAE, 16'd0, "fwd.r0A");
        pushExpect(S_FBE, 16'd0, "fwd.r0B");
        compareQueue();

        // Randomised forwarding against a reference model
        for (int i = 0; i < 24; i++) begin
            rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3)); writeregW = 5'($urandom_range(0, 3));
            regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            fa = (rsE != 0 && rsE == writeregM && regwriteM) ? 2'b10 :
                 (rsE != 0 && rsE == writeregW && regwriteW) ? 2'b01 : 2'b00;
            fb = (rtE != 0 && rtE == writeregM && regwriteM) ? 2'b10 :
                 (rtE != 0 && rtE == writeregW && regwriteW) ? 2'b01 : 2'b00;
            pushExpect(S_FAE, 16'(fa), "rnd.fAE");
            pushExpect(S_FBE, 16'(fb), "rnd.fBE");
            pushExpect(S_FAD, 16'(rsD != 0 && rsD == writeregM && regwriteM), "rnd.fAD");
            pushExpect(S_FBD, 16'(rtD != 0 && rtD == writeregM && regwriteM), "rnd.fBD");
            compareQueue();
        end
        clearInputs();
        doReset();

        // Load-use stall for a single cycle
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        pushStalls(1'b1, 1'b0, 1'b1, "lw");
        compareQueue();
        applyStimulus();
        memtoregE = 1'b0;
        pushStalls(1'b0, 1'b0, 1'b0, "lw.after");
        pushExpect(S_HZC, 16'd1, "lw.hazCnt");
        compareQueue();
        clearInputs();

        // Branch hazards: ALU result in E, load in M, then plain ALU result in M
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rtD = 5'd3;
        pushStalls(1'b1, 1'b0, 1'b1, "brE");
        compareQueue();
        regwriteE = 1'b0; memtoregM = 1'b1; writeregM = 5'd3;
        pushStalls(1'b1, 1'b0, 1'b1, "brM");
        compareQueue();
        memtoregM = 1'b0; regwriteM = 1'b1;
        pushStalls(1'b0, 1'b0, 1'b0, "brFwd");
        pushExpect(S_FBD, 16'd1, "brFwd.fBD");
        compareQueue();
        clearInputs();
        doReset();

        // Memory wait of three cycles with a load-use hazard pending underneath
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8; memreqM = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            pushStalls(1'b1, 1'b1, 1'b0, $sformatf("mw%0d", c));
            pushExpect(S_MWT, 16'(c > 1), $sformatf("mw%0d.memwait", c));
            compareQueue();
            applyStimulus();
        end
        memreadyM = 1'b1;
        pushStalls(1'b1, 1'b0, 1'b1, "mwAck");
        compareQueue();
        applyStimulus();
        clearInputs();
        pushExpect(S_MMC, 16'd3, "mw.memCnt");
        pushExpect(S_HZC, 16'd1, "mw.hazCnt");
        pushExpect(S_MWT, 16'd0, "mw.idle");
        compareQueue();
        doReset();

        // Timeout: one IDLE stall cycle plus TIMEOUT wait cycles, then forced release
        memreqM = 1'b1;
        for (int c = 0; c <= TIMEOUT; c++) begin
            pushExpect(S_STE, 16'd1, $sformatf("to%0d.stallE", c));
            pushExpect(S_MTO, 16'd0, $sformatf("to%0d.timeout", c));
            compareQueue();
            applyStimulus();
        end
        pushExpect(S_MTO, 16'd1, "to.set");
        pushExpect(S_MWT, 16'd0, "to.idle");
        pushExpect(S_STE, 16'd0, "to.release");
        pushExpect(S_MMC, 16'(TIMEOUT + 1), "to.memCnt");
        compareQueue();
        applyStimulus();
        memreqM = 1'b0;
        applyStimulus();
        pushExpect(S_MTO, 16'd1, "to.sticky");
        compareQueue();
        reset = 1'b0;
        pushStalls(1'b0, 1'b0, 1'b0, "to.inRst");
        compareQueue();
        applyStimulus();
        reset = 1'b1;
        pushExpect(S_MTO, 16'd0, "to.cleared");
        pushExpect(S_MMC, 16'd0, "to.memCntClr");
        pushExpect(S_HZC, 16'd0, "to.hazCntClr");
        compareQueue();

        // Hazard counter saturation
        memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        for (int c = 0; c < 20; c++) applyStimulus();
        pushExpect(S_HZC, 16'd15, "sat.hazCnt");
        compareQueue();
        applyStimulus();
        pushExpect(S_HZC, 16'd15, "sat.hold");
        compareQueue();
        clearInputs();

        // Reset in the middle of a wait aborts it without a timeout
        memreqM = 1'b1;
        applyStimulus();
        applyStimulus();
        pushExpect(S_MWT, 16'd1, "rw.inWait");
        compareQueue();
        reset = 1'b0;
        applyStimulus();
        reset = 1'b1;
        memreqM = 1'b0;
        pushExpect(S_MWT, 16'd0, "rw.aborted");
        pushExpect(S_MTO, 16'd0, "rw.noTimeout");
        compareQueue();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
